// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the async FIFO clock-domain-crossing logic.
package fifo_cdc_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    // Helpers work on a wide vector; callers zero-extend and truncate.
    localparam int PW = 32;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic gray_step_ok(
        input logic [PW-1:0] a,
        input logic [PW-1:0] b
    );
        return $countones(a ^ b) <= 1;
    endfunction

endpackage

// File: rtl/sync_r2w_status_chain.sv
// Plain flop chain for crossing a quasi-static value into the local clock.
module sync_chain #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_r2w_status.sv
// Write-side view of the read pointer: sync, Gray->binary, fill level,
// full/almost-full flags and sticky error detection.
module sync_r2w_status
    import fifo_cdc_pkg::*;
#(
    parameter int AWIDTH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LVL   = 12
) (
    input  logic            wr_clk_i,
    input  logic            srst_i,
    input  logic [AWIDTH:0] rd_pntr_gray_i,
    input  logic            rd_empty_i,
    input  logic [AWIDTH:0] wr_pntr_bin_i,
    input  logic            err_clr_i,
    output logic [AWIDTH:0] rd_pntr_gray_o,
    output logic [AWIDTH:0] rd_pntr_bin_o,
    output logic            wr_empty_o,
    output logic [AWIDTH:0] wr_usedw_o,
    output logic            wr_full_o,
    output logic            wr_afull_o,
    output logic [1:0]      err_o
);

    localparam int PTR_W = AWIDTH + 1;
    localparam logic [AWIDTH:0] DEPTH_P = PTR_W'(1 << AWIDTH);
    localparam logic [AWIDTH:0] AFULL_P = PTR_W'(AFULL_LVL);

    generate
        if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES ||
            AFULL_LVL < 1 || AFULL_LVL > (1 << AWIDTH)) begin : g_bad_param
            $error("sync_r2w_status: SYNC_STAGES or AFULL_LVL out of range");
        end
    endgenerate

    logic [AWIDTH:0] gray_sync;
    logic            empty_sync;

    sync_chain #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES),
        .RST_VAL('0)
    ) u_ptr_sync (
        .clk_i (wr_clk_i),
        .srst_i(srst_i),
        .d_i   (rd_pntr_gray_i),
        .q_o   (gray_sync)
    );

    sync_chain #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b1)
    ) u_empty_sync (
        .clk_i (wr_clk_i),
        .srst_i(srst_i),
        .d_i   (rd_empty_i),
        .q_o   (empty_sync)
    );

    logic [AWIDTH:0] rd_bin_q, rd_bin_d;
    logic [AWIDTH:0] prev_gray_q;
    logic [AWIDTH:0] usedw_q, usedw_d;
    logic            full_q, full_d;
    logic            afull_q, afull_d;
    logic [1:0]      err_q, err_d;
    logic [1:0]      err_set;

    always_comb begin
        rd_bin_d = PTR_W'(gray2bin(PW'(gray_sync)));
        // Modulo subtraction takes care of pointer wrap-around.
        usedw_d  = wr_pntr_bin_i - rd_bin_q;
        full_d   = usedw_d >= DEPTH_P;
        afull_d  = usedw_d >= AFULL_P;
        err_set  = 2'b00;
        err_set[0] = !gray_step_ok(PW'(prev_gray_q), PW'(gray_sync));
        // Overflow is judged on the registered level, one cycle after it shows.
        err_set[1] = usedw_q > DEPTH_P;
        err_d = (err_q & ~{2{err_clr_i}}) | err_set;
    end

    always_ff @(posedge wr_clk_i) begin
        if (srst_i) begin
            rd_bin_q    <= '0;
            prev_gray_q <= '0;
            usedw_q     <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            rd_bin_q    <= rd_bin_d;
            prev_gray_q <= gray_sync;
            usedw_q     <= usedw_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            err_q       <= err_d;
        end
    end

    assign rd_pntr_gray_o = gray_sync;
    assign rd_pntr_bin_o  = rd_bin_q;
    assign wr_empty_o     = empty_sync;
    assign wr_usedw_o     = usedw_q;
    assign wr_full_o      = full_q;
    assign wr_afull_o     = afull_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_sync_r2w_status.sv
// Directed bench for sync_r2w_status (AWIDTH=4, S=2, AFULL_LVL=12).
module tb_sync_r2w_status;
    import fifo_cdc_pkg::*;

    logic       clk = 1'b0;
    logic       srst;
    logic [4:0] rd_gray;
    logic       rd_empty;
    logic [4:0] wr_bin;
    logic       clr;
    logic [4:0] gray_o, bin_o, usedw;
    logic       empty_o, full, afull;
    logic [1:0] err;

    int checks = 0;
    int fails  = 0;

    sync_r2w_status #(
        .AWIDTH     (4),
        .SYNC_STAGES(2),
        .AFULL_LVL  (12)
    ) dut (
        .wr_clk_i      (clk),
        .srst_i        (srst),
        .rd_pntr_gray_i(rd_gray),
        .rd_empty_i    (rd_empty),
        .wr_pntr_bin_i (wr_bin),
        .err_clr_i     (clr),
        .rd_pntr_gray_o(gray_o),
        .rd_pntr_bin_o (bin_o),
        .wr_empty_o    (empty_o),
        .wr_usedw_o    (usedw),
        .wr_full_o     (full),
        .wr_afull_o    (afull),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        srst = 1'b1; rd_gray = 5'b00111; rd_empty = 1'b0;
        wr_bin = 5'd7; clr = 1'b0;
        repeat (3) step();
        check("rst_usedw", 32'(usedw), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(afull), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_gray", 32'(gray_o), 32'd0);
        check("rst_bin", 32'(bin_o), 32'd0);

        rd_gray = 5'd0; wr_bin = 5'd0; srst = 1'b0;
        step();
        check("empty_lat1", 32'(empty_o), 32'd1);
        step();
        check("empty_lat2", 32'(empty_o), 32'd0);

        // Latency of pointer, binary and fill level
        rd_gray = 5'b00001; wr_bin = 5'd5;
        step(); step();
        check("lat_gray", 32'(gray_o), 32'd1);
        check("lat_bin_early", 32'(bin_o), 32'd0);
        step();
        check("lat_bin", 32'(bin_o), 32'd1);
        check("lat_usedw_early", 32'(usedw), 32'd5);
        step();
        check("lat_usedw", 32'(usedw), 32'd4);
        check("lat_err", 32'(err), 32'd0);

        // Thresholds
        rd_gray = 5'd0; wr_bin = 5'd16;
        repeat (4) step();
        check("thr16_usedw", 32'(usedw), 32'd16);
        check("thr16_full", 32'(full), 32'd1);
        check("thr16_afull", 32'(afull), 32'd1);
        check("thr16_err", 32'(err), 32'd0);
        wr_bin = 5'd12;
        step();
        check("thr12_usedw", 32'(usedw), 32'd12);
        check("thr12_full", 32'(full), 32'd0);
        check("thr12_afull", 32'(afull), 32'd1);
        wr_bin = 5'd11;
        step();
        check("thr11_usedw", 32'(usedw), 32'd11);
        check("thr11_afull", 32'(afull), 32'd0);

        // Walk read pointer legally up to 30, then wrap write pointer
        for (int b = 1; b <= 30; b++) begin
            rd_gray = 5'(bin2gray(32'(b)));
            wr_bin  = 5'(b);
            step();
        end
        wr_bin = 5'd3;
        repeat (4) step();
        check("wrap_gray", 32'(gray_o), 32'b10001);
        check("wrap_bin", 32'(bin_o), 32'd30);
        check("wrap_usedw", 32'(usedw), 32'd5);
        check("wrap_full", 32'(full), 32'd0);
        check("wrap_err", 32'(err), 32'd0);

        // Return to 0 legally, then make an illegal Gray step
        rd_gray = 5'b10000; wr_bin = 5'd0;
        step();
        rd_gray = 5'd0;
        repeat (5) step();
        check("pre_gray_err", 32'(err), 32'd0);
        check("pre_gray_bin", 32'(bin_o), 32'd0);
        rd_gray = 5'b00011; wr_bin = 5'd2;
        step(); step();
        check("gerr_early", 32'(err), 32'd0);
        step();
        check("gerr_set", 32'(err), 32'b01);
        repeat (2) step();
        check("gerr_sticky", 32'(err), 32'b01);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("gerr_clr", 32'(err), 32'b00);
        rd_gray = 5'd0;
        step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("gerr_set_wins", 32'(err), 32'b01);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("gerr_clr2", 32'(err), 32'b00);

        // Overflow
        wr_bin = 5'd20;
        step();
        check("ovf_usedw", 32'(usedw), 32'd20);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_err_early", 32'(err), 32'b00);
        step();
        check("ovf_err", 32'(err), 32'b10);
        wr_bin = 5'd3;
        step();
        check("ovf_usedw3", 32'(usedw), 32'd3);
        check("ovf_full3", 32'(full), 32'd0);
        check("ovf_sticky", 32'(err), 32'b10);

        // Mid-operation reset
        srst = 1'b1;
        step();
        check("mrst_usedw", 32'(usedw), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        check("mrst_empty", 32'(empty_o), 32'd1);
        srst = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
